// File: rtl/cu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cu_pkg
// Purpose  : Shared types and encodings for the multicycle control unit
//            (FSM states, RV32I opcodes, write-back and branch selects).
// Revision : 1.0 - initial release
// ============================================================================
package cu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } cu_state_t;

    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_iarith = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;

    localparam logic [1:0] c_wb_alu = 2'b00;
    localparam logic [1:0] c_wb_mem = 2'b01;
    localparam logic [1:0] c_wb_pc4 = 2'b10;

    localparam logic [4:0] c_br_none     = 5'b00000;
    localparam logic [1:0] c_br_cond_pfx = 2'b01;
    localparam logic [4:0] c_br_jump     = 5'b10000;

    localparam logic [2:0] c_imm_i = 3'd0;
    localparam logic [2:0] c_imm_s = 3'd1;
    localparam logic [2:0] c_imm_b = 3'd2;
    localparam logic [2:0] c_imm_u = 3'd3;
    localparam logic [2:0] c_imm_j = 3'd4;

    localparam logic [3:0] c_alu_add    = 4'b0000;
    localparam logic [3:0] c_alu_pass_b = 4'b1111;

    // Static, state-independent view of the instruction held in the IR
    typedef struct packed {
        logic       legal;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_jump;
        logic       is_muldiv;
        logic       alu_a_src;
        logic       alu_b_src;
        logic [2:0] imm_sel;
        logic [3:0] alu_op;
        logic [1:0] wb_src;
        logic [2:0] funct3;
    } dec_t;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit_if
// Purpose  : Memory request/ready handshake between control unit and memory.
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_control_unit_if;
    logic       mem_req;
    logic       mem_we;
    logic [2:0] dm_ctrl;
    logic       mem_ready;

    modport master (output mem_req, output mem_we, output dm_ctrl, input mem_ready);
    modport slave  (input mem_req, input mem_we, input dm_ctrl, output mem_ready);
endinterface
`default_nettype wire

// File: rtl/cu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : cu_decoder
// Purpose  : Combinational instruction decoder: static control fields and a
//            legality flag. MULDIV_EN makes Funct7=0000001 R-type legal.
// Revision : 1.0 - initial release
// ============================================================================
module cu_decoder
    import cu_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_unused;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    assign w_unused = ^{instr[24:15], instr[11:7]};

    always_comb begin
        dec        = '0;
        dec.funct3 = w_funct3;
        case (w_opcode)
            c_op_rtype: begin
                dec.alu_op = {w_funct7[5], w_funct3};
                dec.wb_src = c_wb_alu;
                if (w_funct7 == 7'b0000000) begin
                    dec.legal = 1'b1;
                end else if (w_funct7 == 7'b0100000) begin
                    dec.legal = (w_funct3 == 3'b000) || (w_funct3 == 3'b101);
                end else if (w_funct7 == 7'b0000001) begin
`ifdef MULDIV_EN
                    dec.legal     = 1'b1;
                    dec.is_muldiv = 1'b1;
`else
                    dec.legal     = 1'b0;
`endif
                end
            end
            c_op_iarith: begin
                dec.alu_b_src = 1'b1;
                dec.imm_sel   = c_imm_i;
                // Only the right shifts carry an arithmetic/logical bit in Funct7
                if (w_funct3 == 3'b101) begin
                    dec.alu_op = {w_funct7[5], w_funct3};
                    dec.legal  = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
                end else begin
                    dec.alu_op = {1'b0, w_funct3};
                    dec.legal  = (w_funct3 != 3'b001) || (w_funct7 == 7'b0000000);
                end
            end
            c_op_load: begin
                dec.is_load   = 1'b1;
                dec.alu_b_src = 1'b1;
                dec.imm_sel   = c_imm_i;
                dec.alu_op    = c_alu_add;
                dec.wb_src    = c_wb_mem;
                dec.legal     = w_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            end
            c_op_store: begin
                dec.is_store  = 1'b1;
                dec.alu_b_src = 1'b1;
                dec.imm_sel   = c_imm_s;
                dec.alu_op    = c_alu_add;
                dec.legal     = (w_funct3 <= 3'b010);
            end
            c_op_branch: begin
                dec.is_branch = 1'b1;
                dec.imm_sel   = c_imm_b;
                dec.alu_op    = c_alu_add;
                dec.legal     = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
            end
            c_op_jal: begin
                dec.is_jump   = 1'b1;
                dec.alu_a_src = 1'b1;
                dec.alu_b_src = 1'b1;
                dec.imm_sel   = c_imm_j;
                dec.alu_op    = c_alu_add;
                dec.wb_src    = c_wb_pc4;
                dec.legal     = 1'b1;
            end
            c_op_jalr: begin
                dec.is_jump   = 1'b1;
                dec.alu_b_src = 1'b1;
                dec.imm_sel   = c_imm_i;
                dec.alu_op    = c_alu_add;
                dec.wb_src    = c_wb_pc4;
                dec.legal     = (w_funct3 == 3'b000);
            end
            c_op_lui: begin
                dec.alu_b_src = 1'b1;
                dec.imm_sel   = c_imm_u;
                dec.alu_op    = c_alu_pass_b;
                dec.legal     = 1'b1;
            end
            c_op_auipc: begin
                dec.alu_a_src = 1'b1;
                dec.alu_b_src = 1'b1;
                dec.imm_sel   = c_imm_u;
                dec.alu_op    = c_alu_add;
                dec.legal     = 1'b1;
            end
            default: dec.legal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Purpose  : RV32I multicycle control FSM with memory-wait timeout and sticky
//            trap. Optional MULDIV_EN adds a mul/div start/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int ALUOP_W = 4,
    parameter int IMM_W   = 3,
    parameter int WAIT_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    multicycle_control_unit_if.master mem,
    input  logic [31:0]               instr,
    input  logic                      br_taken,
`ifdef MULDIV_EN
    input  logic                      md_done,
    output logic                      md_start,
    output logic [2:0]                md_op,
`endif
    output logic                      ir_wr,
    output logic                      pc_wr,
    output logic                      alu_a_src,
    output logic                      alu_b_src,
    output logic [IMM_W-1:0]          imm_src,
    output logic [ALUOP_W-1:0]        alu_op,
    output logic [1:0]                ru_data_wr_src,
    output logic                      ru_wr,
    output logic [4:0]                br_op,
    output logic [2:0]                state_o,
    output logic                      illegal,
    output logic                      timeout
);

    localparam logic [WAIT_W-1:0] c_wait_one  = {{(WAIT_W-1){1'b0}}, 1'b1};
    // Last count from which one more stalled cycle reaches 2^WAIT_W-1
    localparam logic [WAIT_W-1:0] c_wait_last = ~c_wait_one;

    cu_state_t         r_state;
    cu_state_t         w_state_nxt;
    logic [WAIT_W-1:0] r_wait;
    logic              r_illegal;
    logic              r_timeout;
    dec_t              w_dec;
    logic              w_mem_phase;
    logic              w_ready_seen;
    logic              w_md_wait;
    logic              w_wait_inc;
    logic              w_wait_hit;
    logic              w_set_illegal;
    logic              w_set_timeout;
    logic              w_unused;

    cu_decoder u_decoder (
        .instr (instr),
        .dec   (w_dec)
    );

    // The datapath consumes br_taken directly; the FSM never branches on it
    assign w_unused     = br_taken;
    assign w_mem_phase  = (r_state == ST_FETCH) || (r_state == ST_MEM);
    assign w_ready_seen = w_mem_phase && mem.mem_ready;
    assign w_wait_inc   = (w_mem_phase && !mem.mem_ready) || w_md_wait;
    assign w_wait_hit   = w_wait_inc && (r_wait == c_wait_last);

`ifdef MULDIV_EN
    logic r_md_started;

    assign w_md_wait = (r_state == ST_EXEC) && w_dec.is_muldiv && !md_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_md_started <= 1'b0;
        end else begin
            r_md_started <= (r_state == ST_EXEC) && (w_state_nxt == ST_EXEC);
        end
    end
`else
    assign w_md_wait = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait    <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if ((w_state_nxt != r_state) || w_ready_seen) begin
                r_wait <= '0;
            end else if (w_wait_inc) begin
                r_wait <= r_wait + c_wait_one;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_set_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_set_illegal = 1'b0;
        w_set_timeout = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (mem.mem_ready) begin
                    w_state_nxt = ST_DECODE;
                end else if (w_wait_hit) begin
                    w_state_nxt   = ST_TRAP;
                    w_set_timeout = 1'b1;
                end
            end
            ST_DECODE: begin
                if (w_dec.legal) begin
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt   = ST_TRAP;
                    w_set_illegal = 1'b1;
                end
            end
            ST_EXEC: begin
                if (w_dec.is_branch) begin
                    w_state_nxt = ST_FETCH;
                end else if (w_dec.is_load || w_dec.is_store) begin
                    w_state_nxt = ST_MEM;
`ifdef MULDIV_EN
                end else if (w_dec.is_muldiv) begin
                    if (md_done) begin
                        w_state_nxt = ST_WB;
                    end else if (w_wait_hit) begin
                        w_state_nxt   = ST_TRAP;
                        w_set_timeout = 1'b1;
                    end
`endif
                end else begin
                    w_state_nxt = ST_WB;
                end
            end
            ST_MEM: begin
                if (mem.mem_ready) begin
                    w_state_nxt = w_dec.is_store ? ST_FETCH : ST_WB;
                end else if (w_wait_hit) begin
                    w_state_nxt   = ST_TRAP;
                    w_set_timeout = 1'b1;
                end
            end
            ST_WB:   w_state_nxt = ST_FETCH;
            default: w_state_nxt = ST_TRAP;
        endcase
    end

    // Every enable is qualified by rst_n so reset kills them in the same cycle
    always_comb begin
        ir_wr          = 1'b0;
        pc_wr          = 1'b0;
        mem.mem_req    = 1'b0;
        mem.mem_we     = 1'b0;
        mem.dm_ctrl    = '0;
        alu_a_src      = 1'b0;
        alu_b_src      = 1'b0;
        imm_src        = '0;
        alu_op         = '0;
        ru_data_wr_src = c_wb_alu;
        ru_wr          = 1'b0;
        br_op          = c_br_none;
`ifdef MULDIV_EN
        md_start       = 1'b0;
        md_op          = '0;
`endif
        if (rst_n) begin
            case (r_state)
                ST_FETCH: begin
                    mem.mem_req = 1'b1;
                    ir_wr       = mem.mem_ready;
                end
                ST_EXEC: begin
                    alu_op[3:0]  = w_dec.alu_op;
                    imm_src[2:0] = w_dec.imm_sel;
                    alu_a_src    = w_dec.alu_a_src;
                    alu_b_src    = w_dec.alu_b_src;
                    if (w_dec.is_branch) begin
                        br_op = {c_br_cond_pfx, w_dec.funct3};
                        pc_wr = 1'b1;
                    end
`ifdef MULDIV_EN
                    if (w_dec.is_muldiv) begin
                        md_start = !r_md_started;
                        md_op    = w_dec.funct3;
                    end
`endif
                end
                ST_MEM: begin
                    mem.mem_req = 1'b1;
                    mem.mem_we  = w_dec.is_store;
                    mem.dm_ctrl = w_dec.funct3;
                    pc_wr       = w_dec.is_store && mem.mem_ready;
                end
                ST_WB: begin
                    ru_wr          = 1'b1;
                    pc_wr          = 1'b1;
                    ru_data_wr_src = w_dec.wb_src;
                    if (w_dec.is_jump) begin
                        br_op = c_br_jump;
                    end
                end
                default: ;
            endcase
        end
    end

    assign state_o = r_state;
    assign illegal = r_illegal;
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_unit
// Purpose  : Cycle-by-cycle scoreboard bench for multicycle_control_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;
    import cu_pkg::*;

    localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3, K_JUMP = 4;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_SUB   = 32'h402081B3;
    localparam logic [31:0] I_SRAI  = 32'h4030D213;
    localparam logic [31:0] I_ANDI  = 32'h0070F113;
    localparam logic [31:0] I_ADDI  = 32'h00500093;
    localparam logic [31:0] I_LUI   = 32'h123452B7;
    localparam logic [31:0] I_AUIPC = 32'h00001197;
    localparam logic [31:0] I_LW    = 32'h0080A283;
    localparam logic [31:0] I_SW    = 32'h0050A623;
    localparam logic [31:0] I_BEQ   = 32'h00208463;
    localparam logic [31:0] I_JAL   = 32'h010000EF;
    localparam logic [31:0] I_JALR  = 32'h000100E7;
    localparam logic [31:0] I_MUL   = 32'h022081B3;
    localparam logic [31:0] I_ZERO  = 32'h00000000;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        br_taken;
    logic        ir_wr, pc_wr, alu_a_src, alu_b_src, ru_wr, illegal, timeout;
    logic [2:0]  imm_src;
    logic [3:0]  alu_op;
    logic [1:0]  ru_data_wr_src;
    logic [4:0]  br_op;
    logic [2:0]  state_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    multicycle_control_unit_if mem_if ();

    multicycle_control_unit #(.ALUOP_W(4), .IMM_W(3), .WAIT_W(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem            (mem_if),
        .instr          (instr),
        .br_taken       (br_taken),
        .ir_wr          (ir_wr),
        .pc_wr          (pc_wr),
        .alu_a_src      (alu_a_src),
        .alu_b_src      (alu_b_src),
        .imm_src        (imm_src),
        .alu_op         (alu_op),
        .ru_data_wr_src (ru_data_wr_src),
        .ru_wr          (ru_wr),
        .br_op          (br_op),
        .state_o        (state_o),
        .illegal        (illegal),
        .timeout        (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] st, input logic ir, input logic pc,
                                       input logic mreq, input logic mwe, input logic [2:0] dm,
                                       input logic a, input logic b, input logic [2:0] imm,
                                       input logic [3:0] aop, input logic [1:0] wbs, input logic ru,
                                       input logic [4:0] br, input logic ill, input logic to);
        return {3'b000, st, ir, pc, mreq, mwe, dm, a, b, imm, aop, wbs, ru, br, ill, to};
    endfunction

    function automatic logic [31:0] obs();
        return mk(state_o, ir_wr, pc_wr, mem_if.mem_req, mem_if.mem_we, mem_if.dm_ctrl,
                  alu_a_src, alu_b_src, imm_src, alu_op, ru_data_wr_src, ru_wr, br_op,
                  illegal, timeout);
    endfunction

    // Reference decode of the instruction, written from the ISA semantics
    function automatic void model(input logic [31:0] ins, output int kind, output logic legal,
                                  output logic [3:0] aop, output logic asrc, output logic bsrc,
                                  output logic [2:0] imm, output logic [1:0] wbs);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        kind = K_ALU; legal = 1'b1; aop = 4'h0; asrc = 1'b0; bsrc = 1'b0; imm = 3'd0; wbs = 2'b00;
        case (ins[6:0])
            7'h33: begin
                aop   = {f7[5], f3};
                legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
            end
            7'h13: begin
                bsrc = 1'b1; imm = c_imm_i;
                aop  = (f3 == 3'd5) ? {f7[5], f3} : {1'b0, f3};
                if (f3 == 3'd1) legal = (f7 == 7'h00);
                if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
            end
            7'h03: begin
                kind = K_LOAD; bsrc = 1'b1; imm = c_imm_i; wbs = 2'b01;
                legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
            end
            7'h23: begin kind = K_STORE; bsrc = 1'b1; imm = c_imm_s; legal = (f3 <= 3'd2); end
            7'h63: begin kind = K_BR; imm = c_imm_b; legal = (f3 != 3'd2) && (f3 != 3'd3); end
            7'h6F: begin kind = K_JUMP; asrc = 1'b1; bsrc = 1'b1; imm = c_imm_j; wbs = 2'b10; end
            7'h67: begin kind = K_JUMP; bsrc = 1'b1; imm = c_imm_i; wbs = 2'b10; legal = (f3 == 3'd0); end
            7'h37: begin aop = 4'hF; bsrc = 1'b1; imm = c_imm_u; end
            7'h17: begin asrc = 1'b1; bsrc = 1'b1; imm = c_imm_u; end
            default: legal = 1'b0;
        endcase
    endfunction

    // Drive one cycle of stimulus and record what the DUT must show in it
    task automatic step(input logic rdy, input logic [31:0] e, input string tag);
        mem_if.mem_ready = rdy;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && (exp_q.size() > 0)) begin
            check(tag_q.pop_front(), obs(), exp_q.pop_front());
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        mem_if.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        check("reset_outputs", obs(), 32'h0);
        mem_if.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_instr(input string nm, input logic [31:0] ins, input int fw, input int mw,
                             input logic btk, input logic stop_at_mem);
        int kind;
        logic legal, asrc, bsrc, st;
        logic [3:0] aop;
        logic [2:0] imm, f3;
        logic [1:0] wbs;
        model(ins, kind, legal, aop, asrc, bsrc, imm, wbs);
        f3 = ins[14:12];
        instr = ins;
        br_taken = btk;
        for (int i = 0; i < fw; i++)
            step(1'b0, mk(ST_FETCH, 0, 0, 1, 0, 3'd0, 0, 0, 3'd0, 4'd0, 2'd0, 0, 5'd0, 0, 0), {nm, ":fetch_wait"});
        step(1'b1, mk(ST_FETCH, 1, 0, 1, 0, 3'd0, 0, 0, 3'd0, 4'd0, 2'd0, 0, 5'd0, 0, 0), {nm, ":fetch"});
        step(1'b0, mk(ST_DECODE, 0, 0, 0, 0, 3'd0, 0, 0, 3'd0, 4'd0, 2'd0, 0, 5'd0, 0, 0), {nm, ":decode"});
        if (!legal) begin
            for (int i = 0; i < 10; i++)
                step(i[0], mk(ST_TRAP, 0, 0, 0, 0, 3'd0, 0, 0, 3'd0, 4'd0, 2'd0, 0, 5'd0, 1, 0), {nm, ":trap"});
            return;
        end
        step(1'b1, mk(ST_EXEC, 0, kind == K_BR, 0, 0, 3'd0, asrc, bsrc, imm, aop, 2'd0, 0,
                      (kind == K_BR) ? {2'b01, f3} : 5'd0, 0, 0), {nm, ":exec"});
        if (kind == K_BR) return;
        if ((kind == K_LOAD) || (kind == K_STORE)) begin
            if (stop_at_mem) return;
            st = (kind == K_STORE);
            for (int i = 0; i < mw; i++)
                step(1'b0, mk(ST_MEM, 0, 0, 1, st, f3, 0, 0, 3'd0, 4'd0, 2'd0, 0, 5'd0, 0, 0), {nm, ":mem_wait"});
            step(1'b1, mk(ST_MEM, 0, st, 1, st, f3, 0, 0, 3'd0, 4'd0, 2'd0, 0, 5'd0, 0, 0), {nm, ":mem"});
            if (st) return;
        end
        step(1'b1, mk(ST_WB, 0, 1, 0, 0, 3'd0, 0, 0, 3'd0, 4'd0, wbs, 1,
                      (kind == K_JUMP) ? 5'b10000 : 5'd0, 0, 0), {nm, ":wb"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish by t=100000");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        instr = 32'h0;
        br_taken = 1'b0;
        mem_if.mem_ready = 1'b0;
        do_reset();

        run_instr("add",   I_ADD,   0, 0, 1'b0, 1'b0);
        run_instr("sub",   I_SUB,   2, 0, 1'b0, 1'b0);
        run_instr("srai",  I_SRAI,  0, 0, 1'b0, 1'b0);
        run_instr("andi",  I_ANDI,  1, 0, 1'b0, 1'b0);
        run_instr("addi",  I_ADDI,  0, 0, 1'b0, 1'b0);
        run_instr("lui",   I_LUI,   0, 0, 1'b0, 1'b0);
        run_instr("auipc", I_AUIPC, 0, 0, 1'b0, 1'b0);
        run_instr("lw",    I_LW,    0, 3, 1'b0, 1'b0);
        run_instr("sw",    I_SW,    1, 1, 1'b0, 1'b0);
        run_instr("beq",   I_BEQ,   0, 0, 1'b1, 1'b0);
        run_instr("jal",   I_JAL,   0, 0, 1'b0, 1'b0);
        run_instr("jalr",  I_JALR,  0, 0, 1'b0, 1'b0);
        run_instr("lw_14", I_LW,   14, 14, 1'b0, 1'b0);

        run_instr("op0", I_ZERO, 0, 0, 1'b0, 1'b0);
        do_reset();
        run_instr("mul", I_MUL, 0, 0, 1'b0, 1'b0);
        do_reset();

        // Memory never answers the fetch: 15 stalled cycles, then timeout trap
        for (int i = 0; i < 15; i++)
            step(1'b0, mk(ST_FETCH, 0, 0, 1, 0, 3'd0, 0, 0, 3'd0, 4'd0, 2'd0, 0, 5'd0, 0, 0), "tmo:fetch");
        for (int i = 0; i < 4; i++)
            step(i[0], mk(ST_TRAP, 0, 0, 0, 0, 3'd0, 0, 0, 3'd0, 4'd0, 2'd0, 0, 5'd0, 0, 1), "tmo:trap");
        do_reset();

        // Reset lands in the middle of a stalled store
        run_instr("sw_rst", I_SW, 0, 0, 1'b0, 1'b1);
        mem_if.mem_ready = 1'b0;
        #2;
        check("sw_rst:mem_we_before", {31'b0, mem_if.mem_we}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("sw_rst:mem_we_in_rst", {31'b0, mem_if.mem_we}, 32'h0);
        check("sw_rst:outputs_in_rst", obs(), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("sw_rst:state_after", {29'b0, state_o}, 32'h0);
        check("sw_rst:mem_req_after", {31'b0, mem_if.mem_req}, 32'h1);
        run_instr("add_after", I_ADD, 0, 0, 1'b0, 1'b0);

        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter ALUOP_W, default 4, giving the ALU operation field width (minimum 4).
REQ-002 SHALL have parameter IMM_W, default 3, giving the immediate-select field width.
REQ-003 SHALL have parameter WAIT_W, default 4, giving the memory-wait timeout counter width.
REQ-004 SHALL have port clk, input, 1, as the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, as the reset: asynchronous, active-low.
REQ-006 SHALL have port instr, input, 32, carrying the instruction-register contents (OpCode [6:0], Funct3 [14:12], Funct7 [31:25]).
REQ-007 SHALL have port mem_ready, input, 1, meaning the memory completes the current request this cycle.
REQ-008 SHALL have port br_taken, input, 1, carrying the datapath branch-comparison result.
REQ-009 SHALL have port ir_wr, output, 1, as the instruction-register load enable.
REQ-010 SHALL have port pc_wr, output, 1, as the PC update enable.
REQ-011 SHALL have port mem_req, output, 1, as the memory request.
REQ-012 SHALL have port mem_we, output, 1, as the memory write enable.
REQ-013 SHALL have port dm_ctrl, output, 3, as the data-memory size/sign control.
REQ-014 SHALL have ports alu_a_src, output, 1 (1 = PC), and alu_b_src, output, 1 (1 = immediate).
REQ-015 SHALL have ports imm_src, output, IMM_W, and alu_op, output, ALUOP_W.
REQ-016 SHALL have ports ru_data_wr_src, output, 2 (00 ALU, 01 memory, 10 PC+4), and ru_wr, output, 1.
REQ-017 SHALL have port br_op, output, 5 (00xxx none, 01+Funct3 conditional, 10000 unconditional).
REQ-018 SHALL have ports state_o, output, 3, illegal, output, 1, and timeout, output, 1.

Function
REQ-019 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
REQ-020 FETCH: mem_req=1 until mem_ready; on mem_ready assert ir_wr for exactly one cycle and go to DECODE.
REQ-021 DECODE SHALL last one cycle: legal opcode goes to EXEC; illegal opcode or funct goes to TRAP with illegal=1.
REQ-022 EXEC: drive alu_op as {Funct7[5],Funct3} for R-type and for I-type shifts with Funct3=101; {0,Funct3} for other I-arith; 0000 for load/store/branch/jal/jalr/auipc; 1111 for lui. Zero-extend to ALUOP_W.
REQ-023 EXEC, branch: br_op={01,Funct3}, pc_wr=1 (datapath selects target on br_taken, otherwise PC+4), then go to FETCH.
REQ-024 EXEC, load/store: go to MEM; all other opcodes go to WB.
REQ-025 MEM: mem_req=1, dm_ctrl=Funct3, mem_we=1 for stores only; hold until mem_ready; a store then asserts pc_wr and goes to FETCH, a load goes to WB.
REQ-026 WB: one cycle with ru_wr=1 and pc_wr=1; jal/jalr use ru_data_wr_src=10 and br_op=10000; loads use 01; others use 00. Go to FETCH.
REQ-027 pc_wr and ru_wr SHALL each assert at most once per instruction; ir_wr SHALL never assert outside FETCH.
REQ-028 Wait counter SHALL increment each cycle with mem_req=1 and mem_ready=0, and clear on mem_ready or any state change; on reaching 2^WAIT_W-1, go to TRAP with timeout=1.
REQ-029 TRAP SHALL hold all enables at 0, keep illegal and timeout sticky, and leave only via reset.
REQ-030 Unused control fields SHALL be driven 0, never X.
REQ-031 mem_ready SHALL be ignored outside FETCH and MEM.

Reset
REQ-032 While rst_n=0: state=FETCH, counter=0, illegal=0, timeout=0, and all enables including mem_req forced 0; the first mem_req asserts in the first cycle after release.
REQ-033 Reset asserted mid-instruction SHALL abort immediately with no pending pc_wr or ru_wr.

Configuration
REQ-034 MULDIV_EN defined SHALL add ports md_start (output, 1), md_op (output, 3, =Funct3) and md_done (input, 1).
REQ-035 With MULDIV_EN, R-type with Funct7=0000001 SHALL pulse md_start in its first EXEC cycle and hold EXEC until md_done (counted by the wait counter), then go to WB with src 00.
REQ-036 Without MULDIV_EN, R-type with Funct7=0000001 SHALL be illegal and go to TRAP.

Structure
REQ-037 Package cu_pkg SHALL hold the state enum, opcode constants, ru_data_wr_src and br_op encodings.
REQ-038 Combinational sub-module cu_decoder SHALL map instr to static control fields plus a legal flag; the FSM, counter and gating SHALL be in the top module.

Verification
REQ-039 add x3,x1,x2 with mem_ready=1 -> states 0,1,2,4,0; alu_op=0000; ru_wr=1 for one cycle in WB.
REQ-040 lw with mem_ready low for 3 MEM cycles -> 3 MEM cycles held, then WB with ru_data_wr_src=01, dm_ctrl=010.
REQ-041 beq with br_taken=1 -> br_op=01000, pc_wr=1 in EXEC, ru_wr never 1.
REQ-042 opcode 0000000 -> TRAP at DECODE+1, illegal=1, all enables stay 0 across 10 cycles.
REQ-043 mem_ready held 0 in FETCH with WAIT_W=4 -> timeout=1 and TRAP after 15 cycles.
REQ-044 rst_n low during MEM of sw -> mem_we drops immediately, state_o=0 after release.
